// File: rtl/omp_pkg.sv
// Shared types and sizing helpers for the OMP dispatcher.
package omp_pkg;

  localparam int M_DEF    = 256;
  localparam int LMAX_DEF = 100;
  localparam int DW_DEF   = 32;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    ANNOUNCE,
    WAIT_RW,
    COPY,
    START,
    FLUSH
  } state_t;

  // Address width of one dictionary copy (QW words), never narrower than 1.
  function automatic int aw_of(input int qw);
    return (qw > 1) ? $clog2(qw) : 1;
  endfunction

  function automatic int iw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/omp_dispatch_if.sv
// Dispatcher-to-core bundle: broadcast Q write port, core start/idle/done, X write routing, result flags.
interface omp_dispatch_if #(
  parameter int N_CORES = 4,
  parameter int AW      = 15,
  parameter int DW      = 32
);
  logic [AW-1:0]      q_addr;
  logic [DW-1:0]      q_data;
  logic [N_CORES-1:0] q_we;
  logic [N_CORES-1:0] ap_start;
  logic [N_CORES-1:0] ap_idle;
  logic [N_CORES-1:0] ap_done;
  logic [N_CORES-1:0] x_we;
  logic [N_CORES-1:0] result_ready;

  modport master (
    output q_addr, q_data, q_we, ap_start, x_we, result_ready,
    input  ap_idle, ap_done
  );

  modport slave (
    input  q_addr, q_data, q_we, ap_start, x_we, result_ready,
    output ap_idle, ap_done
  );
endinterface

// File: rtl/omp_rr_arbiter.sv
// Round-robin pick of one requester, searching from (ptr + 1) modulo N_CORES; used only with OMP_DISPATCH_RR_EN.
module omp_rr_arbiter
  import omp_pkg::*;
#(
  parameter int N_CORES = 4,
  localparam int IW = iw_of(N_CORES)
) (
  input  logic [N_CORES-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [N_CORES-1:0] gnt,
  output logic [IW-1:0]      gnt_idx
);

  // Walk the ring backwards so the last hit is the nearest requester after ptr.
  always_comb begin
    int k;
    k       = 0;
    gnt     = '0;
    gnt_idx = '0;
    for (int i = N_CORES; i >= 1; i--) begin
      k = (int'(ptr) + i) % N_CORES;
      if (req[k]) begin
        gnt     = '0;
        gnt[k]  = 1'b1;
        gnt_idx = IW'(k);
      end
    end
  end

endmodule

// File: rtl/omp_dispatch.sv
// Dispatches jobs to external OMP cores: copies the dictionary into the chosen core's Q RAM and collects results.
// Build option OMP_DISPATCH_RR_EN selects round-robin core choice instead of highest-index idle core.
//
// state    | meaning
// IDLE     | wait for a job (data_arrive) or a readback (flush)
// SELECT   | register the chosen idle core in idx
// ANNOUNCE | one-cycle idx_is_set to the host
// WAIT_RW  | host writes X (job) or reads the result (flush) until rw_done
// COPY     | stream QW dictionary words into the selected core's Q RAM
// START    | one-cycle ap_start to the selected core
// FLUSH    | pick the lowest core holding a result, or return to IDLE
module omp_dispatch
  import omp_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int M       = M_DEF,
  parameter int LMAX    = LMAX_DEF,
  parameter int DW      = DW_DEF,
  localparam int QW = M * LMAX,
  localparam int AW = aw_of(QW),
  localparam int IW = iw_of(N_CORES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          data_arrive,
  input  logic          flush,
  input  logic          rw_done,
  output logic          idx_is_set,
  output logic          in_progress,
  output logic [IW-1:0] idx,
  output logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_q,
  input  logic          x_we_in,
  omp_dispatch_if.master core
);

  localparam logic [N_CORES-1:0] ONE_HOT0 = N_CORES'(1);

  state_t             state, state_nx;
  logic [1:0]         rst_sync;
  logic               rst_n;
  logic               flush_mode;
  logic               rd_act;
  logic               q_valid;
  logic [AW-1:0]      q_addr;
  logic [N_CORES-1:0] result_ready;
  logic [N_CORES-1:0] idx_oh;
  logic [N_CORES-1:0] ap_start_c;
  logic [IW-1:0]      sel_idx;
  logic [IW-1:0]      low_idx;
  logic               sel_ok;
  logic               rr_clr;

  // Assert asynchronously, release on a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

`ifdef OMP_DISPATCH_RR_EN
  logic [IW-1:0]      rr_ptr;
  logic [N_CORES-1:0] gnt;

  omp_rr_arbiter #(.N_CORES(N_CORES)) u_arb (
    .req     (core.ap_idle),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (sel_idx)
  );
  assign sel_ok = |gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       rr_ptr <= '0;
    else if (state == SELECT && sel_ok) rr_ptr <= sel_idx;
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int k = 0; k < N_CORES; k++)
      if (core.ap_idle[k]) sel_idx = IW'(k);
  end
  assign sel_ok = |core.ap_idle;
`endif

  always_comb begin
    low_idx = '0;
    for (int k = N_CORES - 1; k >= 0; k--)
      if (result_ready[k]) low_idx = IW'(k);
  end

  assign idx_oh = ONE_HOT0 << idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    idx_is_set = 1'b0;
    ap_start_c = '0;
    case (state)
      IDLE: begin
        if (data_arrive && |core.ap_idle)
          state_nx = SELECT;
        else if (flush && &core.ap_idle && |result_ready)
          state_nx = FLUSH;
      end
      SELECT:   state_nx = sel_ok ? ANNOUNCE : IDLE;
      ANNOUNCE: begin
        idx_is_set = 1'b1;
        state_nx   = WAIT_RW;
      end
      WAIT_RW:  if (rw_done) state_nx = flush_mode ? FLUSH : COPY;
      COPY:     if (!rd_act) state_nx = START;
      START: begin
        ap_start_c = idx_oh;
        state_nx   = IDLE;
      end
      FLUSH:    state_nx = (|result_ready) ? ANNOUNCE : IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Read side issues d_addr; the RAM's output register supplies the one-cycle lag to the Q write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_mode <= 1'b0;
      idx        <= '0;
      d_addr     <= '0;
      q_addr     <= '0;
      rd_act     <= 1'b0;
      q_valid    <= 1'b0;
    end else begin
      q_valid <= 1'b0;
      case (state)
        IDLE:   flush_mode <= (state_nx == FLUSH);
        SELECT: if (sel_ok) idx <= sel_idx;
        WAIT_RW: begin
          if (rw_done && !flush_mode) begin
            d_addr <= '0;
            rd_act <= 1'b1;
          end
        end
        COPY: begin
          if (rd_act) begin
            q_valid <= 1'b1;
            q_addr  <= d_addr;
            if (d_addr == AW'(QW - 1)) rd_act <= 1'b0;
            else                       d_addr <= d_addr + 1'b1;
          end
        end
        FLUSH:  if (|result_ready) idx <= low_idx;
        default: ;
      endcase
    end
  end

  assign rr_clr = (state == WAIT_RW) && rw_done && flush_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_ready <= '0;
    end else begin
      for (int k = 0; k < N_CORES; k++) begin
        if (core.ap_done[k])                 result_ready[k] <= 1'b1;
        else if (rr_clr && idx == IW'(k))    result_ready[k] <= 1'b0;
      end
    end
  end

  assign in_progress       = rd_act | q_valid;
  assign core.q_addr       = q_addr;
  assign core.q_data       = q_valid ? d_q : '0;
  assign core.q_we         = q_valid ? idx_oh : '0;
  assign core.ap_start     = ap_start_c;
  assign core.result_ready = result_ready;
  assign core.x_we         = (rst && rst_n && x_we_in) ? idx_oh : '0;

endmodule

// File: tb/tb_omp_dispatch.sv
// Directed bench for omp_dispatch with N_CORES=4, M=4, LMAX=2 (QW=8); expectations follow the build's arbitration mode.
module tb_omp_dispatch;

`ifdef OMP_DISPATCH_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_arrive = 1'b0;
  logic        flush = 1'b0;
  logic        rw_done = 1'b0;
  logic        x_we_in = 1'b0;
  logic        idx_is_set;
  logic        in_progress;
  logic [1:0]  idx;
  logic [2:0]  d_addr;
  logic [31:0] d_q;
  logic [31:0] ram [8];

  int total = 0;
  int bad   = 0;

  omp_dispatch_if #(.N_CORES(4), .AW(3), .DW(32)) dif ();

  omp_dispatch #(.N_CORES(4), .M(4), .LMAX(2), .DW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_arrive (data_arrive),
    .flush       (flush),
    .rw_done     (rw_done),
    .idx_is_set  (idx_is_set),
    .in_progress (in_progress),
    .idx         (idx),
    .d_addr      (d_addr),
    .d_q         (d_q),
    .x_we_in     (x_we_in),
    .core        (dif.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) d_q <= ram[d_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] oh(input logic [1:0] i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_set();
    int c;
    c = 0;
    do begin
      step();
      c++;
    end while (!idx_is_set && c < 20);
    check("set_seen", idx_is_set, 1);
  endtask

  // abort_at < 0 runs the copy to completion; otherwise reset is asserted at that word.
  task automatic job(input logic [3:0] mask, input logic [1:0] exp_idx, input bit prio, input int abort_at);
    int n, ip, st;
    ap_idle_set(mask);
    data_arrive = 1'b1;
    flush       = prio;
    wait_set();
    data_arrive = 1'b0;
    flush       = 1'b0;
    check("job_idx", idx, exp_idx);
    step();
    check("set_len", idx_is_set, 0);
    x_we_in = 1'b1;
    #1 check("x_we_route", dif.x_we, oh(exp_idx));
    x_we_in = 1'b0;
    #1 check("x_we_off", dif.x_we, 0);
    rw_done = 1'b1;
    step();
    rw_done = 1'b0;
    n = 0; ip = 0; st = 0;
    for (int c = 0; c < 16; c++) begin
      if (in_progress) ip++;
      if (dif.q_we != 4'b0000) begin
        check("q_we", dif.q_we, oh(exp_idx));
        check("q_addr", dif.q_addr, n);
        check("q_data", dif.q_data, ram[n % 8]);
        if (n == abort_at) begin
          rst = 1'b0;
          #1;
          check("abort_q_we", dif.q_we, 0);
          check("abort_inprog", in_progress, 0);
          return;
        end
        n++;
      end
      if (dif.ap_start != 4'b0000) begin
        st++;
        check("ap_start", dif.ap_start, oh(exp_idx));
      end
      step();
    end
    check("words", n, 8);
    check("inprog_len", ip, 9);
    check("starts", st, 1);
    check("d_addr_hold", d_addr, 7);
  endtask

  task automatic ap_idle_set(input logic [3:0] mask);
    dif.ap_idle = mask;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_idx"}, idx, 0);
    check({tag, "_d_addr"}, d_addr, 0);
    check({tag, "_q_addr"}, dif.q_addr, 0);
    check({tag, "_q_data"}, dif.q_data, 0);
    check({tag, "_q_we"}, dif.q_we, 0);
    check({tag, "_ap_start"}, dif.ap_start, 0);
    check({tag, "_set"}, idx_is_set, 0);
    check({tag, "_inprog"}, in_progress, 0);
    check({tag, "_rr"}, dif.result_ready, 0);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 8; i++) ram[i] = 32'hC0DE_0000 + 32'(i * 17 + 3);
    dif.ap_idle = 4'b0000;
    dif.ap_done = 4'b0000;

    #2 rst = 1'b0;
    x_we_in = 1'b1;
    repeat (3) step();
    check_all_zero("rst");
    check("rst_x_we", dif.x_we, 0);
    x_we_in = 1'b0;
    rst = 1'b1;
    repeat (4) step();

    // arbitration and copy
    job(4'b1010, RR ? 2'd1 : 2'd3, 1'b0, -1);
    job(4'b1010, 2'd3, 1'b0, -1);
    job(4'b1111, RR ? 2'd0 : 2'd3, 1'b0, -1);
    job(4'b0100, 2'd2, 1'b0, -1);

    // busy: no idle core, request ignored
    ap_idle_set(4'b0000);
    data_arrive = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (idx_is_set || in_progress) cnt++;
    end
    data_arrive = 1'b0;
    check("busy_activity", cnt, 0);
    check("busy_idx", idx, 2);

    // results on cores 0 and 2, then a job request together with flush
    dif.ap_done = 4'b0101;
    step();
    dif.ap_done = 4'b0000;
    check("rr_set", dif.result_ready, 4'b0101);
    job(4'b1111, 2'd3, 1'b1, -1);
    check("rr_kept", dif.result_ready, 4'b0101);

    // flush readback
    ap_idle_set(4'b1111);
    flush = 1'b1;
    wait_set();
    check("flush_idx0", idx, 0);
    step();
    rw_done = 1'b1;
    step();
    rw_done = 1'b0;
    check("rr_after0", dif.result_ready, 4'b0100);
    wait_set();
    check("flush_idx2", idx, 2);
    step();
    rw_done = 1'b1;
    step();
    rw_done = 1'b0;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (idx_is_set || in_progress) cnt++;
    end
    check("flush_end_activity", cnt, 0);
    check("flush_rr_clear", dif.result_ready, 0);
    flush = 1'b0;

    // reset during copy at word 3
    job(4'b1111, RR ? 2'd0 : 2'd3, 1'b0, 3);
    x_we_in = 1'b1;
    repeat (2) step();
    check("abort_x_we", dif.x_we, 0);
    x_we_in = 1'b0;
    ap_idle_set(4'b0000);
    rst = 1'b1;
    repeat (4) step();
    check_all_zero("post_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/omp_dispatch.md
OMP_DISPATCH -- requirements
Module: omp_dispatch

Interface
REQ-001 SHALL have parameter N_CORES, default 4, number of attached decomposition cores (1..16).
REQ-002 SHALL have parameter M, default 256, signal length in words.
REQ-003 SHALL have parameter LMAX, default 100, dictionary columns; QW = M*LMAX words per copy.
REQ-004 SHALL have parameter DW, default 32, data width; AW = clog2(QW); IW = max(1, clog2(N_CORES)).
REQ-005 SHALL have ports, clock and reset first: clk in 1, single clock; rst in 1, asynchronous active-low reset.
REQ-006 SHALL have ports data_arrive in 1 (job request, level), flush in 1 (readback request, level), rw_done in 1 (host finished X write or result read).
REQ-007 SHALL have ports idx_is_set out 1 and in_progress out 1 (copy active); idx out IW (selected core).
REQ-008 SHALL have ports d_addr out AW (dictionary RAM read address) and d_q in DW (RAM data, 1-cycle latency).
REQ-009 SHALL have ports q_addr out AW, q_data out DW, q_we out N_CORES (broadcast Q write, one-hot).
REQ-010 SHALL have ports ap_start out N_CORES, ap_idle in N_CORES, ap_done in N_CORES.
REQ-011 SHALL have ports x_we_in in 1, x_we out N_CORES (x_we = x_we_in routed to bit idx only, combinational), and result_ready out N_CORES.

Function
REQ-012 SHALL implement states IDLE, SELECT, ANNOUNCE, WAIT_RW, COPY, START, FLUSH.
REQ-013 IDLE: data_arrive=1 and any ap_idle bit =1 -> SELECT; else flush=1, all ap_idle=1 and result_ready!=0 -> FLUSH; data_arrive has priority over flush.
REQ-014 data_arrive with no idle core SHALL be ignored; state stays IDLE.
REQ-015 SELECT SHALL register idx = chosen idle core (REQ-027), then -> ANNOUNCE.
REQ-016 ANNOUNCE SHALL drive idx_is_set=1 for exactly one cycle, then -> WAIT_RW.
REQ-017 WAIT_RW SHALL hold until rw_done=1; in a job, -> COPY; in flush, clear result_ready[idx] and -> FLUSH.
REQ-018 COPY SHALL step d_addr 0..QW-1, one per cycle; q_addr/q_data = d_addr/d_q delayed one cycle; q_we[idx]=1 for exactly QW cycles; in_progress=1 from the first d_addr until the last q_we; total QW+1 cycles.
REQ-019 START SHALL pulse ap_start[idx]=1 for exactly one cycle, then -> IDLE.
REQ-020 result_ready[k] SHALL set on ap_done[k]=1 and clear only per REQ-017 or on reset; set wins on simultaneous set/clear.
REQ-021 FLUSH SHALL select the lowest-index core with result_ready=1 -> ANNOUNCE; when none remain, -> IDLE.
REQ-022 flush or data_arrive changing during COPY SHALL be ignored; a started copy always completes.
REQ-023 d_addr, q_addr SHALL not wrap; the counter stops at QW-1.

Reset
REQ-024 rst=0 SHALL immediately force state IDLE; idx, d_addr, q_addr, q_data, q_we, ap_start, idx_is_set, in_progress, result_ready and the round-robin pointer to 0.
REQ-025 Reset asserted mid-COPY SHALL abort the copy with no further q_we; release is synchronised to clk.
REQ-026 x_we SHALL be 0 while rst=0.

Configuration
REQ-027 With OMP_DISPATCH_RR_EN defined, SELECT SHALL choose the first idle core at or after (last selected +1) modulo N_CORES; without it, SELECT SHALL choose the highest-index idle core and omit the pointer register.

Structure
REQ-028 A shared package omp_pkg SHALL hold the state enum, default M/LMAX/DW and the clog2-derived width helpers.
REQ-029 Sub-module omp_rr_arbiter (N_CORES request mask, pointer -> one-hot grant and index) SHALL be instantiated only under OMP_DISPATCH_RR_EN; the cores themselves SHALL stay external.

Verification
REQ-030 Job copy: N=4, M=4, LMAX=2, all idle, data_arrive, rw_done -> q_we pulses 8 cycles, q_addr 0..7 with q_data = RAM[0..7], then one ap_start pulse.
REQ-031 Arbitration: ap_idle=4'b1010 -> RR build idx=1 then idx=3 on the next job; non-RR build idx=3 both times.
REQ-032 Flush: ap_done pulses on cores 0 and 2, all idle, flush -> idx_is_set for idx 0, then after rw_done for idx 2, then IDLE with result_ready=0.
REQ-033 Priority and busy: data_arrive and flush together with core 1 idle -> job path taken; ap_idle=0 -> no state change.
REQ-034 Reset mid-COPY at word 3: q_we drops the same cycle; after release, state IDLE and all outputs 0.
REQ-035 x_we routing: idx=2, x_we_in=1 -> x_we=4'b0100.
